// File: rtl/hps_master_st_channel_adapter_if.sv
// Avalon-ST bundle for the HPS master channel adapter: upstream sink side,
// downstream source side and the drop statistics.
interface hps_master_st_channel_adapter_if #(
    parameter int DATA_W        = 8,
    parameter int IN_CHANNEL_W  = 8,
    parameter int OUT_CHANNEL_W = 1,
    parameter int CNT_W         = 16
);
    // Handshake: a beat transfers on a rising clk edge where valid and ready
    // are both high; a source holds its beat unchanged while valid & !ready.
    logic                     in_ready;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic [IN_CHANNEL_W-1:0]  in_channel;
    logic                     in_startofpacket;
    logic                     in_endofpacket;

    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [OUT_CHANNEL_W-1:0] out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;

    logic [CNT_W-1:0]         drop_count;
    logic                     drop_pulse;

    modport master (
        output in_ready,
        input  in_valid, in_data, in_channel, in_startofpacket, in_endofpacket,
        input  out_ready,
        output out_valid, out_data, out_channel, out_startofpacket, out_endofpacket,
        output drop_count, drop_pulse
    );

    modport slave (
        input  in_ready,
        output in_valid, in_data, in_channel, in_startofpacket, in_endofpacket,
        output out_ready,
        input  out_valid, out_data, out_channel, out_startofpacket, out_endofpacket,
        input  drop_count, drop_pulse
    );
endinterface

// File: rtl/hps_master_st_channel_adapter.sv
// Registered Avalon-ST channel adapter: forwards packets on channels up to
// MAX_CHANNEL through a skid-buffered output stage, drops and counts the rest.
module hps_master_st_channel_adapter #(
    parameter int DATA_W        = 8,
    parameter int IN_CHANNEL_W  = 8,
    parameter int OUT_CHANNEL_W = 1,
    parameter int MAX_CHANNEL   = 0,
    parameter int CNT_W         = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    hps_master_st_channel_adapter_if.master bus,
    output logic [1:0]                      o_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [IN_CHANNEL_W-1:0] MAX_CH = IN_CHANNEL_W'(MAX_CHANNEL);
    localparam int BEAT_W = DATA_W + OUT_CHANNEL_W + 2;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [OUT_CHANNEL_W-1:0] r_chan;
    logic                     r_in_ready;
    logic                     r_main_valid;
    logic [BEAT_W-1:0]        r_main;
    logic                     r_skid_valid;
    logic [BEAT_W-1:0]        r_skid;
    logic [CNT_W-1:0]         r_drop_count;
    logic                     r_drop_pulse;

    logic                     w_accept;
    logic                     w_legal;
    logic                     w_fwd;
    logic                     w_drop;
    logic                     w_main_free;
    logic                     w_skid_valid_nxt;
    logic [OUT_CHANNEL_W-1:0] w_fwd_chan;
    logic [BEAT_W-1:0]        w_beat;

    // Legality uses the full input channel width so wide channels cannot alias
    // onto legal ones after truncation.
    always_comb begin
        w_accept   = bus.in_valid & r_in_ready;
        w_legal    = (bus.in_channel <= MAX_CH);
        w_fwd_chan = bus.in_startofpacket ? OUT_CHANNEL_W'(bus.in_channel) : r_chan;
        w_beat     = {bus.in_startofpacket, bus.in_endofpacket, w_fwd_chan, bus.in_data};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_drop      = 1'b0;
        if (w_accept) begin
            if (bus.in_startofpacket) begin
                w_fwd  = w_legal;
                w_drop = !w_legal;
                if (bus.in_endofpacket) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = w_legal ? ST_PASS : ST_DROP;
                end
            end else begin
                w_fwd = (r_state == ST_PASS);
                if (bus.in_endofpacket) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    // The skid entry can only be filled while in_ready is high, which in turn
    // requires it to be empty, so a draining main register never meets a new
    // forwarded beat and a full skid entry at the same time.
    always_comb begin
        w_main_free      = !r_main_valid | bus.out_ready;
        w_skid_valid_nxt = w_main_free ? 1'b0 : (r_skid_valid | w_fwd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_chan       <= '0;
            r_in_ready   <= 1'b0;
            r_main_valid <= 1'b0;
            r_main       <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fwd && bus.in_startofpacket) begin
                r_chan <= w_fwd_chan;
            end

            if (w_main_free) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main       <= r_skid;
                end else begin
                    r_main_valid <= w_fwd;
                    if (w_fwd) begin
                        r_main <= w_beat;
                    end
                end
            end else if (w_fwd) begin
                r_skid <= w_beat;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;

            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign bus.in_ready          = r_in_ready;
    assign bus.out_valid         = r_main_valid;
    assign bus.out_startofpacket = r_main[BEAT_W-1];
    assign bus.out_endofpacket   = r_main[BEAT_W-2];
    assign bus.out_channel       = r_main[DATA_W +: OUT_CHANNEL_W];
    assign bus.out_data          = r_main[DATA_W-1:0];
    assign bus.drop_count        = r_drop_count;
    assign bus.drop_pulse        = r_drop_pulse;
    assign o_state               = r_state;
endmodule

// File: tb/tb_hps_master_st_channel_adapter.sv
// Directed bench for hps_master_st_channel_adapter: forwarding, dropping,
// backpressure through the skid buffer, counter saturation and mid-packet reset.
module tb_hps_master_st_channel_adapter;
    localparam int W = 12;  // {sop, eop, channel[1:0], data[7:0]}

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] dut_state;
    always #5 clk = ~clk;

    hps_master_st_channel_adapter_if #(
        .DATA_W(8), .IN_CHANNEL_W(8), .OUT_CHANNEL_W(2), .CNT_W(16)
    ) bus ();

    hps_master_st_channel_adapter #(
        .DATA_W(8), .IN_CHANNEL_W(8), .OUT_CHANNEL_W(2), .MAX_CHANNEL(2), .CNT_W(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .o_state(dut_state)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int pulse_cnt = 0;
    int last_acc_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int obs_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records completed downstream transfers and input accepts.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back({bus.out_startofpacket, bus.out_endofpacket,
                                 bus.out_channel, bus.out_data});
                obs_cyc_q.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.drop_pulse) pulse_cnt++;
        end
    end

    function automatic logic [W-1:0] beat(input logic s, input logic e,
                                          input logic [1:0] ch, input logic [7:0] d);
        return {s, e, ch, d};
    endfunction

    task automatic drive_idle();
        bus.in_valid         = 1'b0;
        bus.in_data          = 8'h00;
        bus.in_channel       = 8'h00;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket   = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [7:0] ch,
                             input logic s, input logic e);
        int waitc;
        waitc = 0;
        bus.in_valid         = 1'b1;
        bus.in_data          = d;
        bus.in_channel       = ch;
        bus.in_startofpacket = s;
        bus.in_endofpacket   = e;
        @(negedge clk);
        while (!bus.in_ready && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1",
                     bus.in_ready, waitc);
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_idle();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_startofpacket, bus.out_endofpacket,
             bus.drop_pulse} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/vld/sop/eop/pulse=%b, expected 00000",
                     {bus.in_ready, bus.out_valid, bus.out_startofpacket,
                      bus.out_endofpacket, bus.drop_pulse});
        end
        n_tests++;
        if ({bus.out_data, bus.out_channel} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h chan=%h, expected 0", bus.out_data, bus.out_channel);
        end
        n_tests++;
        if (bus.drop_count !== 16'h0 || dut_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_count_state: got count=%h state=%0d, expected 0/0",
                     bus.drop_count, dut_state);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got in_ready=%b, expected 0", bus.in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_rise: got in_ready=%b out_valid=%b, expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_single_packet();
        int first_acc;
        do_reset();
        first_acc = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(beat(i == 0, i == 3, 2'd1, 8'(8'h11 + i)));
            send_beat(8'(8'h11 + i), 8'd1, i == 0, i == 3);
            if (i == 0) first_acc = last_acc_cyc;
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL t1_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_cyc_q[i] !== first_acc + i) begin
                n_fail++;
                $display("FAIL t1_beat%0d: got %h at cycle %0d, expected %h at cycle %0d",
                         i, obs_q[i], obs_cyc_q[i], exp_q[i], first_acc + i);
            end
        end
        n_tests++;
        if (bus.drop_count !== 16'h0) begin
            n_fail++;
            $display("FAIL t1_drop_count: got %h, expected 0000", bus.drop_count);
        end
    endtask

    task automatic test_drop_then_pass();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        send_beat(8'hA1, 8'd5, 1'b1, 1'b0);
        n_tests++;
        if (bus.drop_pulse !== 1'b1 || bus.drop_count !== 16'd1) begin
            n_fail++;
            $display("FAIL t2_drop_now: got pulse=%b count=%h, expected 1/0001",
                     bus.drop_pulse, bus.drop_count);
        end
        send_beat(8'hA2, 8'd5, 1'b0, 1'b0);
        n_tests++;
        if (bus.drop_pulse !== 1'b0 || dut_state !== 2'd2) begin
            n_fail++;
            $display("FAIL t2_drop_state: got pulse=%b state=%0d, expected 0/2",
                     bus.drop_pulse, dut_state);
        end
        send_beat(8'hA3, 8'd5, 1'b0, 1'b1);
        exp_q.push_back(beat(1'b1, 1'b0, 2'd2, 8'h21));
        exp_q.push_back(beat(1'b0, 1'b1, 2'd2, 8'h22));
        send_beat(8'h21, 8'd2, 1'b1, 1'b0);
        send_beat(8'h22, 8'd7, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL t2_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL t2_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (pulse_cnt - p0 !== 1 || bus.drop_count !== 16'd1) begin
            n_fail++;
            $display("FAIL t2_pulse_total: got pulses=%0d count=%h, expected 1/0001",
                     pulse_cnt - p0, bus.drop_count);
        end
    endtask

    task automatic test_single_beat_drop();
        do_reset();
        send_beat(8'h31, 8'd3, 1'b1, 1'b1);
        n_tests++;
        if (bus.drop_count !== 16'd1 || dut_state !== 2'd0 || bus.drop_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_drop_ch3: got count=%h state=%0d pulse=%b, expected 0001/0/1",
                     bus.drop_count, dut_state, bus.drop_pulse);
        end
        send_beat(8'h32, 8'h82, 1'b1, 1'b1);
        n_tests++;
        if (bus.drop_count !== 16'd2) begin
            n_fail++;
            $display("FAIL t3_drop_wide_ch: got count=%h, expected 0002", bus.drop_count);
        end
        exp_q.push_back(beat(1'b1, 1'b1, 2'd0, 8'h33));
        send_beat(8'h33, 8'd0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (obs_q.size() !== 1 || obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL t3_fwd_ch0: got %0d beats first=%h, expected 1 beat %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 12'h0, exp_q[0]);
        end
        n_tests++;
        if (dut_state !== 2'd0) begin
            n_fail++;
            $display("FAIL t3_state: got %0d, expected 0", dut_state);
        end
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(beat(i == 0, i == 7, 2'd1, 8'(8'h41 + i)));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_beat(8'(8'h41 + i), 8'd1, i == 0, i == 7);
                end
            end
            begin
                logic [W-1:0] held;
                int a1;
                held = '0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                a1 = acc_cnt;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) begin
                        held = {bus.out_startofpacket, bus.out_endofpacket,
                                bus.out_channel, bus.out_data};
                    end else begin
                        n_tests++;
                        if ({bus.out_startofpacket, bus.out_endofpacket, bus.out_channel,
                             bus.out_data} !== held || bus.out_valid !== 1'b1) begin
                            n_fail++;
                            $display("FAIL t4_hold%0d: got %h valid=%b, expected %h valid=1", k,
                                     {bus.out_startofpacket, bus.out_endofpacket,
                                      bus.out_channel, bus.out_data}, bus.out_valid, held);
                        end
                        n_tests++;
                        if (bus.in_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL t4_in_ready%0d: got %b, expected 0", k, bus.in_ready);
                        end
                    end
                end
                @(posedge clk);
                #1;
                n_tests++;
                if (acc_cnt - a1 !== 1) begin
                    n_fail++;
                    $display("FAIL t4_skid_absorb: got %0d accepts during stall, expected 1",
                             acc_cnt - a1);
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL t4_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL t4_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.in_channel       = 8'd3;
        bus.in_data          = 8'h00;
        bus.in_startofpacket = 1'b1;
        bus.in_endofpacket   = 1'b1;
        bus.in_valid         = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        n_tests++;
        if (bus.drop_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL t5_count_fffe: got %h, expected fffe", bus.drop_count);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.drop_count !== 16'hFFFF || bus.drop_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_count_ffff: got count=%h pulse=%b, expected ffff/1",
                     bus.drop_count, bus.drop_pulse);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.drop_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_pulse_idle: got %b, expected 0", bus.drop_pulse);
        end
        send_beat(8'h55, 8'd3, 1'b1, 1'b1);
        n_tests++;
        if (bus.drop_count !== 16'hFFFF || bus.drop_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_saturate: got count=%h pulse=%b, expected ffff/1",
                     bus.drop_count, bus.drop_pulse);
        end
    endtask

    task automatic test_reset_mid_packet();
        int p0;
        do_reset();
        exp_q.push_back(beat(1'b1, 1'b0, 2'd1, 8'h61));
        send_beat(8'h61, 8'd1, 1'b1, 1'b0);
        send_beat(8'h62, 8'd1, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_startofpacket, bus.out_endofpacket,
             bus.out_channel, bus.out_data} !== 14'h0 || dut_state !== 2'd0) begin
            n_fail++;
            $display("FAIL t6_reset_outputs: got rdy=%b vld=%b beat=%h state=%0d, expected all 0",
                     bus.in_ready, bus.out_valid, {bus.out_startofpacket, bus.out_endofpacket,
                     bus.out_channel, bus.out_data}, dut_state);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        p0 = pulse_cnt;
        send_beat(8'h63, 8'd1, 1'b0, 1'b0);
        send_beat(8'h64, 8'd1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (obs_q.size() !== 1 || obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL t6_orphans: got %0d beats first=%h, expected 1 beat %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 12'h0, exp_q[0]);
        end
        n_tests++;
        if (bus.drop_count !== 16'h0 || pulse_cnt - p0 !== 0 || dut_state !== 2'd0) begin
            n_fail++;
            $display("FAIL t6_no_drop: got count=%h pulses=%0d state=%0d, expected 0/0/0",
                     bus.drop_count, pulse_cnt - p0, dut_state);
        end
    endtask

    initial begin
        drive_idle();
        bus.out_ready = 1'b1;
        test_reset();
        test_single_packet();
        test_drop_then_pass();
        test_single_beat_drop();
        test_back_to_back_stall();
        test_saturation();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hps_master_st_channel_adapter.md
# hps_master_st_channel_adapter

Registered, parametrised Avalon-ST channel adapter for the HPS master bytes-to-packets path. It replaces the fixed 8-bit, single-channel combinational adapter. Data width, channel widths and the highest legal destination channel are configurable. Packets addressed to channels above that limit are dropped whole, and each drop is counted. The block sits between the bytes-to-packets converter and the packet-to-transaction master, and registers all outputs through a skid buffer so timing is closed at full throughput.

## Interface
- DATA_W, 8: payload width in bits.
- IN_CHANNEL_W, 8: width of in_channel.
- OUT_CHANNEL_W, 1: width of out_channel; at least 1.
- MAX_CHANNEL, 0: highest channel forwarded; must be ≤ 2^OUT_CHANNEL_W−1.
- CNT_W, 16: width of drop_count.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_ready  out  1  upstream backpressure.
- in_valid  in  1  upstream beat valid.
- in_data  in  DATA_W  upstream payload.
- in_channel  in  IN_CHANNEL_W  upstream channel; only meaningful on SOP beats.
- in_startofpacket  in  1  SOP marker.
- in_endofpacket  in  1  EOP marker.
- out_ready  in  1  downstream backpressure.
- out_valid  out  1  downstream beat valid.
- out_data  out  DATA_W  downstream payload.
- out_channel  out  OUT_CHANNEL_W  channel latched at SOP, truncated to OUT_CHANNEL_W.
- out_startofpacket  out  1  SOP marker.
- out_endofpacket  out  1  EOP marker.
- drop_count  out  CNT_W  packets dropped since reset; saturates at all-ones.
- drop_pulse  out  1  one-cycle strobe per dropped packet.

## Operation
- Accept: in_valid & in_ready. Only accepted beats affect state. Non-accepted cycles change nothing.
- Packet FSM states: IDLE (between packets), PASS (forwarding), DROP (discarding). Reset state is IDLE.
- Legality check: SOP beat is legal iff the unsigned in_channel ≤ MAX_CHANNEL. The comparison uses the full IN_CHANNEL_W width, before truncation.
- Accepted SOP beat, evaluated from any state:
  - Legal: forward the beat, latch the channel, and go to PASS. If EOP is also set, go to IDLE instead.
  - Illegal: discard the beat, increment drop_count, pulse drop_pulse, and go to DROP. If EOP is also set, go to IDLE instead.
  - An SOP arriving in PASS silently truncates the previous packet; no EOP is synthesised.
- Accepted non-SOP beat:
  - In PASS: forward with out_channel = latched channel (mid-packet in_channel changes are ignored). EOP → IDLE.
  - In DROP: discard. EOP → IDLE.
  - In IDLE: orphan beat. Discard it and leave the counter unchanged.
- Discarded beats are still accepted (consumed). They never reach the output stage.
- Output stage: a main output register plus a one-entry skid register.
  - in_ready = skid empty, registered.
  - When out_ready is low and the main register is full, a forwarded beat goes to the skid register.
  - When the main register drains, the skid entry moves into it.
  - Beat order is preserved. Downstream never sees a beat dropped or duplicated.
- Output hold: out_data, out_channel, out_startofpacket and out_endofpacket hold steady while out_valid & !out_ready.
- drop_count: saturating. At all-ones, further drops leave it unchanged but still pulse drop_pulse.

## Timing
- Reset values (while reset is high, and at the first edge after deassertion):
  - in_ready=0, out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, drop_count=0, drop_pulse=0.
  - FSM in IDLE; skid register empty.
- in_ready rises one cycle after reset deasserts.
- Reset asserted mid-packet: the output beat and skid contents are discarded and the FSM returns to IDLE. A packet still in flight upstream after reset is then seen as orphans until its next SOP.
- Latency: 1 cycle from an accepted forwarded beat to out_valid, provided the output register is empty or draining.
- Throughput: 1 beat/cycle sustained with out_ready held high.
- Backpressure:
  - out_ready low while a beat is held: one further beat may be accepted into the skid register, then in_ready falls on the next cycle.
  - in_ready rises the cycle after the skid register empties.
- drop_pulse asserts in the cycle after the illegal SOP is accepted. drop_count updates at the same edge.
- No combinational path from out_ready or any in_* signal to any output.

## Test plan
Parameters for all scenarios unless stated: DATA_W=8, IN_CHANNEL_W=8, OUT_CHANNEL_W=2, MAX_CHANNEL=2.

1. Reset, then a 4-beat packet on channel 1 (data 0x11..0x14) with out_ready high → out_valid from cycle +1 for 4 consecutive cycles, data 0x11..0x14, out_channel=1, SOP on first beat, EOP on last; drop_count=0.
2. 3-beat packet on channel 5, then a 2-beat packet on channel 2 → no output for channel 5; drop_pulse one cycle; drop_count=1; channel-2 packet is forwarded intact with out_channel=2.
3. Single-beat SOP+EOP packet on channel 3 → discarded; FSM stays IDLE; drop_count=1. Next SOP beat on channel 0 is forwarded.
4. out_ready low for 5 cycles during an 8-beat stream, with in_valid held high → exactly one beat is absorbed into the skid register before in_ready falls. All 8 beats exit in order with no duplicates, and outputs are stable while stalled.
5. Force drop_count to 0xFFFF via 65535 dropped single-beat packets, then drop one more → drop_count stays 0xFFFF; drop_pulse still asserts.
6. Assert reset mid-packet on channel 1 after 2 beats, then resume feeding beats 3..4 without SOP → all outputs reset. Beats 3..4 are discarded as orphans, with no drop_count change.
